// File: rtl/fadd_rr_sched.sv
// rtl/fadd_rr_sched.sv - round-robin scheduler sharing one flotAdd among NREQ requesters
//
// Arbitrates NREQ processing-element requests onto a single external 8-bit float adder.
// It registers the winning operands onto add_a/add_b and carries a {valid,id} tag alongside
// the adder latency. Each sum is returned tagged with the requester that issued it.
//
// Optional feature: define FADD_RR_SCHED_CNT_EN to enable the saturating granted-op counter.
// When it is not defined, op_cnt is tied to zero.
//
// Ports:
//   clk        clock, all logic on posedge
//   rst        asynchronous reset, active-high
//   en         1 = accept new requests, 0 = drain in-flight ops then idle
//   req        per-requester request, held with operands until granted
//   req_a      operand A, requester i on bits [8i+7:8i]
//   req_b      operand B, same packing as req_a
//   gnt        one-hot combinational grant, accepted at the current edge
//   add_a      registered operand A to the adder
//   add_b      registered operand B to the adder
//   add_out    adder result
//   rsp_valid  one-cycle pulse, result valid
//   rsp_id     requester ID of the result
//   rsp_data   sum
//   busy       1 while the scheduler is not idle
//   sign_err   sticky, set when a granted operand has bit 7 set
//   op_cnt     granted-op count (zero unless FADD_RR_SCHED_CNT_EN)

module fadd_rr_sched #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int ADD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   gnt,
  output logic [7:0]        add_a,
  output logic [7:0]        add_b,
  input  logic [7:0]        add_out,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_data,
  output logic              busy,
  output logic              sign_err,
  output logic [15:0]       op_cnt
);

  // One stage covers the operand register; ADD_LAT more stages cover the adder itself.
  localparam int DEPTH = ADD_LAT + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [DEPTH-1:0] tag_v;
  logic [IDW-1:0] tag_id [DEPTH];

  logic           found;
  logic           grant;
  logic [IDW-1:0] win;
  logic [IDW-1:0] cand;
  logic [7:0]     win_a;
  logic [7:0]     win_b;
  int             tmp;

  // Search starts one past the last winner so the last winner has the lowest priority.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    tmp   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      tmp  = (int'(rr_ptr) + k) % NREQ;
      cand = IDW'(tmp);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    grant = !rst && (state == RUN) && en && found;
    gnt   = '0;
    if (grant) begin
      gnt[win] = 1'b1;
    end
    win_a = req_a[{win, 3'b000} +: 8];
    win_b = req_b[{win, 3'b000} +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      rr_ptr    <= IDW'(NREQ - 1);
      add_a     <= 8'h00;
      add_b     <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= 8'h00;
      sign_err  <= 1'b0;
      tag_v     <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        tag_id[j] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!en) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // Re-enable wins over completion so a quick en toggle never idles with work queued.
          if (en) begin
            state <= RUN;
          end else if (tag_v == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (grant) begin
        rr_ptr <= win;
        add_a  <= win_a;
        add_b  <= win_b;
        if (win_a[7] || win_b[7]) begin
          sign_err <= 1'b1;
        end
      end

      // A bubble tag is pushed on cycles without a grant so positions stay in lockstep
      // with the adder pipeline.
      tag_v     <= {tag_v[DEPTH-2:0], grant};
      tag_id[0] <= grant ? win : '0;
      for (int j = 1; j < DEPTH; j++) begin
        tag_id[j] <= tag_id[j-1];
      end

      rsp_valid <= tag_v[DEPTH-1];
      rsp_id    <= tag_id[DEPTH-1];
      if (tag_v[DEPTH-1]) begin
        rsp_data <= add_out;
      end
    end
  end

`ifdef FADD_RR_SCHED_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_cnt <= 16'h0000;
    end else if (grant && (op_cnt != 16'hFFFF)) begin
      op_cnt <= op_cnt + 16'h0001;
    end
  end
`else
  assign op_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fadd_rr_sched.sv
// tb/tb_fadd_rr_sched.sv - self-checking bench for fadd_rr_sched with a behavioural adder and scoreboard

module tb_fadd_rr_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [NREQ-1:0]   gnt;
  logic [7:0]        add_a;
  logic [7:0]        add_b;
  logic [7:0]        add_out = 8'h00;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_data;
  logic              busy;
  logic              sign_err;
  logic [15:0]       op_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fadd_rr_sched #(.NREQ(NREQ), .IDW(IDW), .ADD_LAT(1)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .add_a(add_a), .add_b(add_b), .add_out(add_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy), .sign_err(sign_err), .op_cnt(op_cnt)
  );

  // Behavioural flotAdd: value = 1.mant * 2^exp, positive only, truncating, saturating.
  function automatic logic [7:0] fadd(input logic [7:0] a, input logic [7:0] b);
    int ea, eb, ma, mb, e, s;
    ea = int'(a[6:4]); eb = int'(b[6:4]);
    ma = 16 + int'(a[3:0]); mb = 16 + int'(b[3:0]);
    if (ea >= eb) begin e = ea; s = ma + (mb >> (ea - eb)); end
    else          begin e = eb; s = mb + (ma >> (eb - ea)); end
    if (s >= 32) begin s = s >> 1; e = e + 1; end
    if (e > 7) return 8'h7F;
    return {1'b0, 3'(e), 4'(s - 16)};
  endfunction

  always @(posedge clk) add_out <= fadd(add_a, add_b);

  function automatic int onehot_id(input logic [NREQ-1:0] g);
    int id;
    id = -1;
    if ($countones(g) == 1)
      for (int i = 0; i < NREQ; i++) if (g[i]) id = i;
    return id;
  endfunction

  // Scoreboard: every grant predicts a response three cycles later with the model sum.
  typedef struct { int due; int id; logic [7:0] data; } exp_t;
  exp_t sbq[$];
  int   cyc = 0;
  int   mptr = NREQ - 1;
  int   grants_since_rst = 0;
  int   mw;
  logic [NREQ-1:0] exp_g;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sbq.delete();
      mptr = NREQ - 1;
      grants_since_rst = 0;
      n_chk++;
      if (gnt !== '0 || rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_quiet: gnt=%b rsp_valid=%b required gnt=0000 rsp_valid=0", gnt, rsp_valid);
      end
    end else begin
      n_chk++;
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        if (rsp_valid !== 1'b1 || int'(rsp_id) != sbq[0].id || rsp_data !== sbq[0].data) begin
          n_fail++;
          $display("FAIL rsp_match cyc %0d: valid=%b id=%0d data=%h required valid=1 id=%0d data=%h",
                   cyc, rsp_valid, rsp_id, rsp_data, sbq[0].id, sbq[0].data);
        end
        void'(sbq.pop_front());
      end else if (rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rsp_spurious cyc %0d: rsp_valid=%b required 0", cyc, rsp_valid);
      end
      if (gnt !== '0) begin
        mw = -1;
        for (int k = 1; k <= NREQ; k++)
          if (mw < 0 && req[(mptr + k) % NREQ]) mw = (mptr + k) % NREQ;
        exp_g = (mw < 0) ? '0 : NREQ'(1 << mw);
        n_chk++;
        if (gnt !== exp_g || en !== 1'b1) begin
          n_fail++;
          $display("FAIL grant_pick cyc %0d: gnt=%b en=%b required gnt=%b en=1", cyc, gnt, en, exp_g);
        end
        if (mw >= 0) begin
          sbq.push_back('{cyc + 3, mw, fadd(req_a[8*mw +: 8], req_b[8*mw +: 8])});
          mptr = mw;
          grants_since_rst++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; req = '1;
    req_a = $urandom; req_b = $urandom;
    repeat (2) @(negedge clk);
    n_chk++;
    if (gnt !== '0 || add_a !== 8'h00 || add_b !== 8'h00 || rsp_valid !== 1'b0 || rsp_id !== '0 ||
        rsp_data !== 8'h00 || busy !== 1'b0 || sign_err !== 1'b0 || op_cnt !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_state: gnt=%b a=%h b=%h v=%b id=%0d d=%h busy=%b se=%b cnt=%h required all zero",
               gnt, add_a, add_b, rsp_valid, rsp_id, rsp_data, busy, sign_err, op_cnt);
    end
    step(); rst = 1'b0; en = 1'b0; req = '0;
    step();
  endtask

  task automatic test_single();
    en = 1'b1;
    step();
    req = 4'b0001; req_a[7:0] = 8'h10; req_b[7:0] = 8'h10;
    @(negedge clk);
    n_chk++;
    if (gnt !== 4'b0001) begin
      n_fail++; $display("FAIL single_gnt: gnt=%b required 0001", gnt);
    end
    step(); req = '0;
    @(negedge clk);
    n_chk++;
    if (add_a !== 8'h10 || add_b !== 8'h10) begin
      n_fail++; $display("FAIL single_operands: add_a=%h add_b=%h required 10 10", add_a, add_b);
    end
    step(); step();
    @(negedge clk);
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 8'h20) begin
      n_fail++;
      $display("FAIL single_rsp: valid=%b id=%0d data=%h required 1 0 20", rsp_valid, rsp_id, rsp_data);
    end
    step();
  endtask

  task automatic test_round_robin();
    int g[14];
    int r[$];
    int first;
    rst = 1'b1; step();
    rst = 1'b0; en = 1'b1; req = '0; step();
    first = -1;
    req = '1;
    for (int c = 0; c < 14; c++) begin
      req_a = $urandom & 32'h7F7F7F7F; req_b = $urandom & 32'h7F7F7F7F;
      @(negedge clk);
      g[c] = onehot_id(gnt);
      if (rsp_valid === 1'b1) begin
        r.push_back(int'(rsp_id));
        if (first < 0) first = c;
      end
      step();
      if (c == 7) req = '0;
    end
    for (int c = 0; c < 8; c++) begin
      n_chk++;
      if (g[c] != c % 4) begin
        n_fail++; $display("FAIL rr_order slot %0d: granted %0d required %0d", c, g[c], c % 4);
      end
    end
    n_chk++;
    if (r.size() != 8 || first != 3) begin
      n_fail++; $display("FAIL rr_rsp_count: pulses=%0d first=%0d required 8 at 3", r.size(), first);
    end
    for (int c = 0; c < r.size(); c++) begin
      n_chk++;
      if (r[c] != c % 4) begin
        n_fail++; $display("FAIL rr_rsp_id slot %0d: id=%0d required %0d", c, r[c], c % 4);
      end
    end
  endtask

  task automatic test_alternate();
    int g;
    req = 4'b0101;
    for (int c = 0; c < 8; c++) begin
      req_a = $urandom & 32'h7F7F7F7F; req_b = $urandom & 32'h7F7F7F7F;
      @(negedge clk);
      g = onehot_id(gnt);
      n_chk++;
      if (g != ((c % 2 == 0) ? 0 : 2)) begin
        n_fail++; $display("FAIL alt_order slot %0d: granted %0d required %0d", c, g, (c % 2 == 0) ? 0 : 2);
      end
      step();
    end
    req = '0;
    repeat (4) step();
  endtask

  task automatic test_en_drop();
    int pulses, late_g, last;
    logic b[16];
    pulses = 0; late_g = 0; last = -1;
    req = '1;
    for (int c = 0; c < 16; c++) begin
      if (c == 3) en = 1'b0;
      req_a = $urandom & 32'h7F7F7F7F; req_b = $urandom & 32'h7F7F7F7F;
      @(negedge clk);
      b[c] = busy;
      if (c >= 3 && gnt !== '0) late_g++;
      if (rsp_valid === 1'b1) begin pulses++; last = c; end
      step();
    end
    req = '0;
    n_chk++;
    if (late_g != 0 || pulses != 3) begin
      n_fail++; $display("FAIL drain_counts: late grants=%0d pulses=%0d required 0 3", late_g, pulses);
    end
    n_chk++;
    if (last < 0 || last > 14 || b[last] !== 1'b1 || b[last + 1] !== 1'b0) begin
      n_fail++; $display("FAIL drain_busy: last pulse slot %0d required busy 1 then 0 (slot 5/6)", last);
    end
  endtask

  task automatic test_sign_cnt();
    en = 1'b1; step();
    req = 4'b0010; req_a[15:8] = 8'h90; req_b[15:8] = 8'h10;
    @(negedge clk);
    n_chk++;
    if (gnt !== 4'b0010) begin
      n_fail++; $display("FAIL sign_gnt: gnt=%b required 0010", gnt);
    end
    step(); req = 4'b0001; req_a[7:0] = 8'h22; req_b[7:0] = 8'h31;
    @(negedge clk);
    n_chk++;
    if (sign_err !== 1'b1) begin
      n_fail++; $display("FAIL sign_set: sign_err=%b required 1", sign_err);
    end
    repeat (4) step();
    req = '0;
    repeat (5) step();
    @(negedge clk);
    n_chk++;
    if (sign_err !== 1'b1) begin
      n_fail++; $display("FAIL sign_sticky: sign_err=%b required 1", sign_err);
    end
    n_chk++;
`ifdef FADD_RR_SCHED_CNT_EN
    if (op_cnt !== 16'(grants_since_rst)) begin
      n_fail++; $display("FAIL op_cnt: op_cnt=%0d required %0d", op_cnt, grants_since_rst);
    end
`else
    if (op_cnt !== 16'h0000) begin
      n_fail++; $display("FAIL op_cnt: op_cnt=%0d required 0", op_cnt);
    end
`endif
  endtask

  task automatic test_reset_midstream();
    req = '1;
    repeat (2) step();
    rst = 1'b1; req = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_chk++;
      if (rsp_valid !== 1'b0 || gnt !== '0 || op_cnt !== 16'h0000) begin
        n_fail++;
        $display("FAIL midreset: rsp_valid=%b gnt=%b op_cnt=%0d required 0", rsp_valid, gnt, op_cnt);
      end
      step();
    end
    rst = 1'b0; en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL post_reset_idle: busy=%b rsp_valid=%b required 0 0", busy, rsp_valid);
      end
      step();
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] prev_g;
    logic en_prev;
    prev_g = '0; en_prev = en;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (prev_g[i] || !req[i]) begin
          if ($urandom_range(2) != 0) begin
            req[i] = 1'b1;
            req_a[8*i +: 8] = 8'($urandom) & 8'h7F;
            req_b[8*i +: 8] = 8'($urandom) & 8'h7F;
          end else begin
            req[i] = 1'b0;
          end
        end
      end
      if ($urandom_range(19) == 0) en = ~en;
      @(negedge clk);
      if (en_prev && en && req != '0) begin
        n_chk++;
        if (gnt === '0) begin
          n_fail++; $display("FAIL random_liveness cyc %0d: gnt=0 with req=%b", cyc, req);
        end
      end
      en_prev = en; prev_g = gnt;
      step();
    end
    en = 1'b0; req = '0;
    repeat (10) step();
    @(negedge clk);
    n_chk++;
    if (sbq.size() != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL random_drain: outstanding=%0d busy=%b required 0 0", sbq.size(), busy);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = '0; req_a = '0; req_b = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_alternate();
    test_en_drop();
    test_sign_cnt();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
